// File: rtl/beat_period_meter_if.sv
// rtl/beat_period_meter_if.sv - beat/tick inputs and period/average results of the beat period meter
//
// Purpose: groups the per-sample tick, the beat pulse and the measurement
// results into one bundle.
// Ports (master = stimulus side, slave = meter side):
//   count_en     master->slave  one-cycle pulse per audio sample
//   beat_in      master->slave  one-cycle pulse per beat
//   period       slave->master  sample count of the last completed interval
//   period_valid slave->master  one-cycle pulse when period updates
//   avg_period   slave->master  mean of the last four completed intervals
//   avg_valid    slave->master  one-cycle pulse when avg_period updates
//   timeout      slave->master  level, high while a beat is overdue
interface beat_period_meter_if #(
    parameter int SIGNAL_WIDTH = 16
);
    logic                    count_en;
    logic                    beat_in;
    logic [SIGNAL_WIDTH-1:0] period;
    logic                    period_valid;
    logic [SIGNAL_WIDTH-1:0] avg_period;
    logic                    avg_valid;
    logic                    timeout;

    modport master (
        output count_en, beat_in,
        input  period, period_valid, avg_period, avg_valid, timeout
    );

    modport slave (
        input  count_en, beat_in,
        output period, period_valid, avg_period, avg_valid, timeout
    );
endinterface

// File: rtl/beat_period_meter.sv
// rtl/beat_period_meter.sv - measures sample counts between beats and their 4-interval running mean
//
// Purpose: counts count_en ticks between consecutive beat_in pulses, reports
// each completed interval and, once four intervals are in history, their mean.
// A beat that does not arrive within TIMEOUT_COUNT ticks parks the meter in
// TIMEOUT until the next beat re-arms it.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    beat_period_meter_if.slave (count_en, beat_in in;
//          period, period_valid, avg_period, avg_valid, timeout out)
module beat_period_meter #(
    parameter int          SIGNAL_WIDTH  = 16,
    parameter int unsigned TIMEOUT_COUNT = 'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    beat_period_meter_if.slave  bus
);
    localparam int W = SIGNAL_WIDTH;
    localparam logic [W:0] TIMEOUT_LIM = (W+1)'(TIMEOUT_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hist_q [4];
    logic [W-1:0] hist_d [4];
    logic [2:0]   fill_q, fill_d;
    logic [W-1:0] period_q, period_d;
    logic         pv_q, pv_d;
    logic [W-1:0] avg_q, avg_d;
    logic         av_q, av_d;

    // One bit wider than the counter so the limit compare cannot wrap.
    logic [W:0]   cnt_inc;
    logic         hit_limit;
    logic [W+1:0] sum;

    assign cnt_inc   = {1'b0, cnt_q} + (W+1)'(bus.count_en);
    assign hit_limit = (cnt_inc >= TIMEOUT_LIM);
    assign sum       = (W+2)'(hist_q[0]) + (W+2)'(hist_q[1])
                     + (W+2)'(hist_q[2]) + (W+2)'(hist_q[3]);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.beat_in) state_d = S_MEASURE;
            S_MEASURE: if (!bus.beat_in && hit_limit) state_d = S_TIMEOUT;
            S_TIMEOUT: if (bus.beat_in) state_d = S_MEASURE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        period_d = period_q;
        pv_d     = 1'b0;
        avg_d    = avg_q;
        av_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_MEASURE: begin
                if (bus.beat_in) begin
                    // A tick landing on the beat cycle belongs to the closing interval.
                    period_d  = cnt_inc[W-1:0];
                    pv_d      = 1'b1;
                    cnt_d     = '0;
                    hist_d[0] = hist_q[1];
                    hist_d[1] = hist_q[2];
                    hist_d[2] = hist_q[3];
                    hist_d[3] = cnt_inc[W-1:0];
                    fill_d    = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                end else if (hit_limit) begin
                    cnt_d = TIMEOUT_LIM[W-1:0];
                end else begin
                    cnt_d = cnt_inc[W-1:0];
                end
            end
            S_TIMEOUT: begin
                // Counter stays saturated; a beat only re-arms.
                fill_d = 3'd0;
                if (bus.beat_in) cnt_d = '0;
            end
            default: cnt_d = '0;
        endcase
        // History registers already hold the new period when pv_q is high.
        if (pv_q && fill_q == 3'd4) begin
            av_d  = 1'b1;
            avg_d = sum[W+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            fill_q   <= 3'd0;
            period_q <= '0;
            pv_q     <= 1'b0;
            avg_q    <= '0;
            av_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
            fill_q   <= fill_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            avg_q    <= avg_d;
            av_q     <= av_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.avg_period   = avg_q;
    assign bus.avg_valid    = av_q;
    assign bus.timeout      = (state_q == S_TIMEOUT);
endmodule

// File: tb/tb_beat_period_meter.sv
// tb/tb_beat_period_meter.sv - self-checking bench for beat_period_meter
module tb_beat_period_meter;
    localparam int W   = 16;
    localparam int GAP = 9;

    logic clk = 1'b0;
    logic rst_main;
    logic rst_to;
    always #5 clk = ~clk;

    beat_period_meter_if #(.SIGNAL_WIDTH(W)) bus();
    beat_period_meter_if #(.SIGNAL_WIDTH(W)) bus_to();

    beat_period_meter #(.SIGNAL_WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_main),
        .bus   (bus)
    );

    beat_period_meter #(.SIGNAL_WIDTH(W), .TIMEOUT_COUNT(20)) dut_to (
        .clk   (clk),
        .reset (rst_to),
        .bus   (bus_to)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     val;
        longint due;
    } exp_t;
    exp_t exp_p[$];
    exp_t exp_a[$];

    typedef struct {
        int ticks;
        bit coincide;
        bit exp_pv;
        int exp_period;
        bit exp_av;
        int exp_avg;
    } vec_t;
    vec_t vecs[12];

    int pv_to_n = 0;
    int av_to_n = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic cyc1(input bit w, input bit ce, input bit bt);
        if (w) begin
            bus_to.count_en = ce;
            bus_to.beat_in  = bt;
        end else begin
            bus.count_en = ce;
            bus.beat_in  = bt;
        end
        @(posedge clk);
        #1;
        bus.count_en    = 1'b0;
        bus.beat_in     = 1'b0;
        bus_to.count_en = 1'b0;
        bus_to.beat_in  = 1'b0;
    endtask

    task automatic tick(input bit w);
        repeat (GAP) cyc1(w, 1'b0, 1'b0);
        cyc1(w, 1'b1, 1'b0);
    endtask

    // n ticks then a beat; with coincide the beat shares the n-th tick cycle.
    task automatic beat(input bit w, input int n, input bit coincide,
                        input bit push_pv, input int per, input bit push_av, input int avg);
        exp_t e;
        for (int i = 0; i < n - (coincide ? 1 : 0); i++) tick(w);
        if (coincide) repeat (GAP) cyc1(w, 1'b0, 1'b0);
        if (!w && push_pv) begin
            e.val = per;
            e.due = cyc + 1;
            exp_p.push_back(e);
        end
        if (!w && push_av) begin
            e.val = avg;
            e.due = cyc + 2;
            exp_a.push_back(e);
        end
        cyc1(w, coincide, 1'b1);
    endtask

    // Scoreboard for the main instance: pops on each output pulse, checks value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_main) begin
            if (bus.period_valid) begin
                if (exp_p.size() == 0) begin
                    flag("pv_unexpected", $sformatf("period=%0d at cycle %0d", bus.period, cyc));
                end else begin
                    e = exp_p.pop_front();
                    chk("period", bus.period, e.val);
                    chk("period_cycle", cyc, e.due);
                end
            end else if (exp_p.size() > 0 && exp_p[0].due < cyc) begin
                e = exp_p.pop_front();
                flag("pv_missing", $sformatf("expected period=%0d at cycle %0d", e.val, e.due));
            end
            if (bus.avg_valid) begin
                if (exp_a.size() == 0) begin
                    flag("av_unexpected", $sformatf("avg=%0d at cycle %0d", bus.avg_period, cyc));
                end else begin
                    e = exp_a.pop_front();
                    chk("avg_period", bus.avg_period, e.val);
                    chk("avg_cycle", cyc, e.due);
                end
            end else if (exp_a.size() > 0 && exp_a[0].due < cyc) begin
                e = exp_a.pop_front();
                flag("av_missing", $sformatf("expected avg=%0d at cycle %0d", e.val, e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_to) begin
            if (bus_to.period_valid) pv_to_n++;
            if (bus_to.avg_valid) av_to_n++;
        end
    end

    initial begin
        vecs[0]  = '{0,   1'b0, 1'b0, 0,   1'b0, 0};
        vecs[1]  = '{48,  1'b0, 1'b1, 48,  1'b0, 0};
        vecs[2]  = '{48,  1'b0, 1'b1, 48,  1'b0, 0};
        vecs[3]  = '{48,  1'b0, 1'b1, 48,  1'b0, 0};
        vecs[4]  = '{48,  1'b0, 1'b1, 48,  1'b1, 48};
        vecs[5]  = '{48,  1'b0, 1'b1, 48,  1'b1, 48};
        vecs[6]  = '{100, 1'b0, 1'b1, 100, 1'b1, 61};
        vecs[7]  = '{104, 1'b0, 1'b1, 104, 1'b1, 75};
        vecs[8]  = '{96,  1'b0, 1'b1, 96,  1'b1, 87};
        vecs[9]  = '{102, 1'b0, 1'b1, 102, 1'b1, 100};
        vecs[10] = '{48,  1'b1, 1'b1, 48,  1'b1, 87};
        vecs[11] = '{0,   1'b0, 1'b1, 0,   1'b1, 61};

        bus.count_en    = 1'b0;
        bus.beat_in     = 1'b0;
        bus_to.count_en = 1'b0;
        bus_to.beat_in  = 1'b0;
        rst_main = 1'b1;
        rst_to   = 1'b1;
        repeat (3) cyc1(1'b0, 1'b0, 1'b0);

        chk("rst_period",       bus.period, 0);
        chk("rst_period_valid", bus.period_valid, 0);
        chk("rst_avg_period",   bus.avg_period, 0);
        chk("rst_avg_valid",    bus.avg_valid, 0);
        chk("rst_timeout",      bus.timeout, 0);

        rst_main = 1'b0;
        for (int i = 0; i < 12; i++) begin
            beat(1'b0, vecs[i].ticks, vecs[i].coincide, vecs[i].exp_pv,
                 vecs[i].exp_period, vecs[i].exp_av, vecs[i].exp_avg);
        end
        repeat (4) cyc1(1'b0, 1'b0, 1'b0);
        chk("no_timeout_main", bus.timeout, 0);

        // Reset mid-interval with three intervals in history; reset wins over beat and tick.
        rst_main = 1'b1;
        cyc1(1'b0, 1'b0, 1'b0);
        rst_main = 1'b0;
        beat(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) beat(1'b0, 10, 1'b0, 1'b1, 10, 1'b0, 0);
        repeat (5) tick(1'b0);
        rst_main = 1'b1;
        cyc1(1'b0, 1'b1, 1'b1);
        rst_main = 1'b0;
        chk("midrst_period",       bus.period, 0);
        chk("midrst_period_valid", bus.period_valid, 0);
        chk("midrst_avg_period",   bus.avg_period, 0);
        chk("midrst_avg_valid",    bus.avg_valid, 0);
        chk("midrst_timeout",      bus.timeout, 0);
        beat(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        chk("rearm_no_pv", bus.period_valid, 0);
        beat(1'b0, 10, 1'b0, 1'b1, 10, 1'b0, 0);
        repeat (4) cyc1(1'b0, 1'b0, 1'b0);

        // Timeout behaviour on the instance with TIMEOUT_COUNT = 20.
        rst_to = 1'b0;
        beat(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0);
        beat(1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 0);
        cyc1(1'b1, 1'b0, 1'b0);
        chk("to_first_period", bus_to.period, 5);
        chk("to_first_pv_count", pv_to_n, 1);
        repeat (19) tick(1'b1);
        chk("to_before_limit", bus_to.timeout, 0);
        tick(1'b1);
        chk("to_at_limit", bus_to.timeout, 1);
        chk("to_cnt_at_limit", dut_to.cnt_q, 20);
        repeat (5) tick(1'b1);
        chk("to_held", bus_to.timeout, 1);
        chk("to_cnt_saturated", dut_to.cnt_q, 20);
        chk("to_period_kept", bus_to.period, 5);
        cyc1(1'b1, 1'b0, 1'b1);
        chk("to_cleared", bus_to.timeout, 0);
        cyc1(1'b1, 1'b0, 1'b0);
        chk("to_rearm_no_pv", pv_to_n, 1);
        beat(1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0);
        cyc1(1'b1, 1'b0, 1'b0);
        chk("to_period_7", bus_to.period, 7);
        chk("to_pv_count", pv_to_n, 2);
        repeat (3) cyc1(1'b1, 1'b0, 1'b0);
        chk("to_no_avg", av_to_n, 0);

        chk("pv_queue_empty", exp_p.size(), 0);
        chk("av_queue_empty", exp_a.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
